alu_arbiter: RTL and testbench

- Two-requester front end for the registered 32-bit ALU (one-cycle registered result, opcodes 0-7).
- Accepts operation requests over valid/ready handshakes and arbitrates round-robin between them.
- Drives the ALU operand/opcode bus, captures the registered result and flags, and returns them to the winning requester over a valid/ready response channel.
- Serialises accesses: exactly one operation in flight at a time.

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the registered ALU.
// One operation in flight; result and flags are returned to the winning requester.
module alu_arbiter #(
  parameter int NUMBITS = 32,
  parameter int CNTBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req0_opcode,
  input  logic [NUMBITS-1:0] req0_a,
  input  logic [NUMBITS-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2:0]         req1_opcode,
  input  logic [NUMBITS-1:0] req1_a,
  input  logic [NUMBITS-1:0] req1_b,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [NUMBITS-1:0] rsp_result,
  output logic               rsp_carryout,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic [2:0]         alu_opcode,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               busy,
  output logic [CNTBITS-1:0] ops_done
);

  // state   | meaning
  // IDLE    | waiting for a request; grant issued combinationally
  // ISSUE   | latched operation on the ALU bus; ALU registers result at end
  // CAPTURE | ALU result/flags valid; copied into rsp registers
  // RESP    | response offered to owner until its ready
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   last_grant;
  logic   grant_vld;
  logic   grant_id;
  logic   rsp_fire;

  localparam logic [CNTBITS-1:0] CNT_ONE = {{(CNTBITS-1){1'b0}}, 1'b1};

  // Round-robin pick: on contention the requester that did not win last time goes.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~last_grant;
    end else if (req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        rsp_fire   = owner ? rsp1_ready : rsp0_ready;
        if (rsp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The ALU bus doubles as the operand latch, so it holds the last issued op between operations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (state == IDLE && grant_vld) begin
      owner      <= grant_id;
      last_grant <= grant_id;
      alu_opcode <= grant_id ? req1_opcode : req0_opcode;
      alu_a      <= grant_id ? req1_a      : req0_a;
      alu_b      <= grant_id ? req1_b      : req0_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (state == CAPTURE) begin
      rsp_result   <= alu_result;
      rsp_carryout <= alu_carryout;
      rsp_overflow <= alu_overflow;
      rsp_zero     <= alu_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_done <= '0;
    end else if (rsp_fire) begin
      ops_done <= ops_done + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered stand-in ALU.
// A second instance with CNTBITS=2 runs in lockstep to exercise counter wrap.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_ready, rsp1_ready;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_result;
  logic        rsp_carryout, rsp_overflow, rsp_zero;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_carryout, alu_overflow, alu_zero;
  logic        busy;
  logic [15:0] ops_done;

  logic        w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid;
  logic [31:0] w_rsp_result;
  logic        w_rsp_carryout, w_rsp_overflow, w_rsp_zero;
  logic [2:0]  w_alu_opcode;
  logic [31:0] w_alu_a, w_alu_b;
  logic        w_busy;
  logic [1:0]  w_ops_done;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUMBITS(32), .CNTBITS(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .busy(busy), .ops_done(ops_done)
  );

  alu_arbiter #(.NUMBITS(32), .CNTBITS(2)) dut_wrap (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(w_rsp_result), .rsp_carryout(w_rsp_carryout),
    .rsp_overflow(w_rsp_overflow), .rsp_zero(w_rsp_zero),
    .alu_opcode(w_alu_opcode), .alu_a(w_alu_a), .alu_b(w_alu_b),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .busy(w_busy), .ops_done(w_ops_done)
  );

  // Stand-in ALU: 0/1 add, 2 xor, 3 sub, 4 and, 5 nand, 6 or, 7 nor; one-cycle registered.
  function automatic logic [34:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, o;
    s = {1'b0, a} + {1'b0, b};
    c = 1'b0;
    o = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        r = s[31:0];
        c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd2:    r = a ^ b;
      3'd3:    r = a - b;
      3'd4:    r = a & b;
      3'd5:    r = ~(a & b);
      3'd6:    r = a | b;
      default: r = ~(a | b);
    endcase
    return {c, o, (r == 32'd0), r};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {alu_carryout, alu_overflow, alu_zero, alu_result} <= '0;
    end else begin
      {alu_carryout, alu_overflow, alu_zero, alu_result} <= alu_fn(alu_opcode, alu_a, alu_b);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_count(input string tag);
    check({tag, " ops_done"}, ops_done, exp_ops & 16'hFFFF);
    check({tag, " ops_done_wrap"}, w_ops_done, exp_ops & 3);
  endtask

  task automatic run_op(input bit who, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input logic eo, input logic ez,
                        input string tag);
    int n;
    if (who) begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
    end
    #1;
    n = 0;
    while (!(who ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
    check({tag, " grant"}, who ? req1_ready : req0_ready, 1'b1);
    check({tag, " other_ready"}, who ? req0_ready : req1_ready, 1'b0);
    tick();
    // Scramble the request after acceptance; the in-flight op must not change.
    if (who) begin
      req1_valid = 1'b0; req1_a = 32'hDEAD_BEEF; req1_b = 32'h1234_5678; req1_opcode = 3'd7;
    end else begin
      req0_valid = 1'b0; req0_a = 32'hDEAD_BEEF; req0_b = 32'h1234_5678; req0_opcode = 3'd7;
    end
    #1;
    check({tag, " alu_a"}, alu_a, a);
    check({tag, " alu_opcode"}, alu_opcode, op);
    check({tag, " ready_in_issue"}, req0_ready | req1_ready, 1'b0);
    n = 1;
    while (!(who ? rsp1_valid : rsp0_valid) && n < 10) begin tick(); n++; end
    check({tag, " latency"}, n, 3);
    check({tag, " result"}, rsp_result, er);
    check({tag, " carry"}, rsp_carryout, ec);
    check({tag, " overflow"}, rsp_overflow, eo);
    check({tag, " zero"}, rsp_zero, ez);
    check({tag, " other_rsp"}, who ? rsp0_valid : rsp1_valid, 1'b0);
    check({tag, " busy_resp"}, busy, 1'b1);
    if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    exp_ops++;
    check_count(tag);
    check({tag, " busy_after"}, busy, 1'b0);
    check({tag, " alu_a_held"}, alu_a, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  who;
    bit  seen;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opcode = '0; req1_opcode = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst readies", {req0_ready, req1_ready}, 2'b00);
    check("rst rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    check("rst result", rsp_result, 32'd0);
    check("rst flags", {rsp_carryout, rsp_overflow, rsp_zero}, 3'b000);
    check("rst alu_bus", {alu_opcode, alu_a, alu_b}, 67'd0);
    check_count("rst");

    run_op(1'b0, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, "add5_7");
    run_op(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1, "carry");
    run_op(1'b1, 3'd1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "overflow");

    // Backpressure on requester 1 while requester 0 waits.
    req1_valid = 1'b1; req1_opcode = 3'd6; req1_a = 32'hF0; req1_b = 32'h0F;
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin tick(); n++; end
    check("bp grant1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_opcode = 3'd2; req0_a = 32'd3; req0_b = 32'd3;
    #1;
    check("bp ready0_issue", req0_ready, 1'b0);
    n = 1;
    while (!rsp1_valid && n < 10) begin tick(); n++; end
    check("bp rsp1_latency", n, 3);
    for (int i = 0; i < 10; i++) begin
      check("bp hold result", rsp_result, 32'hFF);
      check("bp hold valid", {rsp0_valid, rsp1_valid}, 2'b01);
      check("bp hold busy", busy, 1'b1);
      check("bp hold ready0", req0_ready, 1'b0);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    check("bp ready0_handshake", req0_ready, 1'b0);
    tick();
    rsp1_ready = 1'b0;
    exp_ops++;
    check_count("bp rsp1");
    check("bp ready0_next", req0_ready, 1'b1);
    check("bp busy_next", busy, 1'b0);
    tick();
    req0_valid = 1'b0;
    n = 1;
    while (!rsp0_valid && n < 10) begin tick(); n++; end
    check("bp rsp0_latency", n, 3);
    check("bp rsp0_result", rsp_result, 32'd0);
    check("bp rsp0_zero", rsp_zero, 1'b1);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    exp_ops++;
    check_count("bp rsp0");

    // Reset while the op sits in CAPTURE.
    req0_valid = 1'b1; req0_opcode = 3'd0; req0_a = 32'd1; req0_b = 32'd1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin tick(); n++; end
    check("ar grant", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("ar busy_capture", busy, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("ar busy", busy, 1'b0);
    check("ar alu_bus", {alu_opcode, alu_a, alu_b}, 67'd0);
    check("ar result", rsp_result, 32'd0);
    check("ar rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    exp_ops = 0;
    check_count("ar");
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
      tick();
    end
    check("ar no_rsp_after", seen, 1'b0);
    check_count("ar after");

    // Round robin with both requesters always valid and responses taken at once.
    req0_valid = 1'b1; req0_opcode = 3'd2; req0_a = 32'd3; req0_b = 32'd3;
    req1_valid = 1'b1; req1_opcode = 3'd6; req1_a = 32'hF0; req1_b = 32'h0F;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin tick(); n++; end
      check("rr both_ready", req0_ready & req1_ready, 1'b0);
      check("rr order", req1_ready, k % 2);
      who = req1_ready;
      tick();
      n = 1;
      while (!(who ? rsp1_valid : rsp0_valid) && n < 10) begin tick(); n++; end
      check("rr latency", n, 3);
      check("rr result", rsp_result, who ? 32'hFF : 32'd0);
      check("rr zero", rsp_zero, who ? 1'b0 : 1'b1);
      tick();
      exp_ops++;
      check_count("rr");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
